// File: rtl/isq_lin.sv
// -----------------------------------------------------------------------------
// isq_lin -- one storage line (entry) of the issue queue.
//
// The line holds one instruction payload plus two status bits: valid (val)
// and waiting (wat). The issue-queue array instantiates one isq_lin per entry,
// and its control logic drives the per-line strobes below.
//
// Line layout, MSB first:
//    [ISQ_LINE_WIDTH-1]   val
//    [ISQ_LINE_WIDTH-2]   wat
//    [INST_WIDTH-1:0]     instruction payload
//
// Update priority at each rising edge (rst_n high), highest first:
//    fls  -> whole line zeroed, every other strobe ignored
//    en   -> whole line loaded from isq_lin_in, set/clear strobes ignored
//    else -> val and wat updated independently (clear beats set), payload holds
//
// Ports:
//    clk          in   system clock, rising-edge active
//    rst_n        in   asynchronous active-low reset, zeroes the line
//    en           in   load enable, writes isq_lin_in into the line
//    clr_wat      in   clear waiting bit
//    set_wat      in   set waiting bit
//    clr_val      in   clear valid bit
//    set_val      in   set valid bit
//    fls          in   flush, zeroes the entire line
//    isq_lin_in   in   line data to load  [ISQ_LINE_WIDTH-1:0]
//    isq_lin_out  out  current line contents, straight from the register
// -----------------------------------------------------------------------------
module isq_lin #(
   parameter int INST_WIDTH     = 14,
   // Derived from INST_WIDTH; overriding it on its own is an elaboration error.
   parameter int ISQ_LINE_WIDTH = INST_WIDTH + 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      en,
   input  logic                      clr_wat,
   input  logic                      set_wat,
   input  logic                      clr_val,
   input  logic                      set_val,
   input  logic                      fls,
   input  logic [ISQ_LINE_WIDTH-1:0] isq_lin_in,
   output logic [ISQ_LINE_WIDTH-1:0] isq_lin_out
);

   // Catch an inconsistent parameter override at elaboration time rather than
   // silently mis-slicing the status bits.
   generate
      if (ISQ_LINE_WIDTH != INST_WIDTH + 2) begin : g_bad_width
         $error("isq_lin: ISQ_LINE_WIDTH must equal INST_WIDTH + 2");
      end
   endgenerate

   // Field view of the line; packing order matches the MSB-first layout.
   typedef struct packed {
      logic                  val;
      logic                  wat;
      logic [INST_WIDTH-1:0] inst;
   } line_t;

   line_t r_line;   // the one and only storage register
   line_t w_nxt;    // next-state value

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: default to the current value first so every path assigns w_nxt;
      // an unassigned path in always_comb would infer a latch.
      w_nxt = r_line;

      if (fls) begin
         w_nxt = '0;
      end else if (en) begin
         w_nxt = line_t'(isq_lin_in);
      end else begin
         // Clear is tested first so it wins a same-cycle set/clear conflict.
         if (clr_val)      w_nxt.val = 1'b0;
         else if (set_val) w_nxt.val = 1'b1;

         if (clr_wat)      w_nxt.wat = 1'b0;
         else if (set_wat) w_nxt.wat = 1'b1;
      end
   end

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   // NOTE: the reset branch is in the sensitivity list, so rst_n low clears the
   // line immediately without waiting for a clock edge; state is assigned
   // with <= so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_line <= '0;
      end else begin
         r_line <= w_nxt;
      end
   end

   // Output is the register itself: no combinational path from any input.
   assign isq_lin_out = r_line;

endmodule

// File: tb/tb_isq_lin.sv
// -----------------------------------------------------------------------------
// tb_isq_lin -- self-checking bench for isq_lin (default parameters).
//
// A behavioural model keeps val, wat and the payload as separate variables and
// applies the line rules to them after every rising edge; the DUT output is
// compared with the model and, for the directed steps, with literal values.
// Inputs change one ns after the rising edge and outputs are sampled at the
// same point, well away from the active edge.
// -----------------------------------------------------------------------------
module tb_isq_lin;

   localparam int IW = 14;
   localparam int LW = IW + 2;

   logic          clk;
   logic          rst_n;
   logic          en;
   logic          clr_wat;
   logic          set_wat;
   logic          clr_val;
   logic          set_val;
   logic          fls;
   logic [LW-1:0] isq_lin_in;
   logic [LW-1:0] isq_lin_out;

   isq_lin #(
      .INST_WIDTH (IW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .clr_wat     (clr_wat),
      .set_wat     (set_wat),
      .clr_val     (clr_val),
      .set_val     (set_val),
      .fls         (fls),
      .isq_lin_in  (isq_lin_in),
      .isq_lin_out (isq_lin_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------------------
   // Reference model: the line as three separate fields.
   // ---------------------------------------------------------------------------
   bit          m_val;
   bit          m_wat;
   bit [IW-1:0] m_inst;

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   function automatic logic [LW-1:0] model_line();
      return {m_val, m_wat, m_inst};
   endfunction

   task automatic model_reset();
      m_val  = 1'b0;
      m_wat  = 1'b0;
      m_inst = '0;
   endtask

   // Apply one rising edge's worth of effect using the inputs held across it.
   task automatic model_edge();
      if (fls) begin
         model_reset();
      end else if (en) begin
         m_val  = isq_lin_in[LW-1];
         m_wat  = isq_lin_in[LW-2];
         m_inst = isq_lin_in[IW-1:0];
      end else begin
         if (clr_val || set_val) m_val = !clr_val;
         if (clr_wat || set_wat) m_wat = !clr_wat;
      end
   endtask

   task automatic check(input string tag, input logic [LW-1:0] expv);
      n_chk++;
      assert (isq_lin_out === expv) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, isq_lin_out, expv);
      end
   endtask

   task automatic drive(input logic e, input logic f,
                        input logic sv, input logic cv,
                        input logic sw, input logic cw,
                        input logic [LW-1:0] d);
      en         = e;
      fls        = f;
      set_val    = sv;
      clr_val    = cv;
      set_wat    = sw;
      clr_wat    = cw;
      isq_lin_in = d;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
   endtask

   // One clock: wait for the edge, update the model, compare against it.
   task automatic tick(input string tag);
      @(posedge clk);
      #1;
      model_edge();
      check(tag, model_line());
   endtask

   // Reset pulse placed between edges; the line must clear with no clock edge.
   task automatic async_reset_pulse(input string tag);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check(tag, '0);
      #1;
      rst_n = 1'b1;
   endtask

   // Watchdog: the sequence below is a few thousand ns long.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [LW-1:0] rnd_in;
      int            r;

      // ------------------------------------------------------------ reset
      idle();
      rst_n = 1'b0;
      model_reset();
      #3;
      check("reset_state", 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      tick("post_reset_hold");
      check("post_reset_zero", 16'h0000);

      // Preload all ones, then reset asynchronously mid-cycle.
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'hffff);
      tick("preload_ffff");
      check("preload_ffff_c", 16'hffff);
      idle();
      async_reset_pulse("reset_async_mid");
      tick("reset_release_hold");
      check("reset_release_zero", 16'h0000);

      // ------------------------------------------------------------ load
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'hfbab);
      tick("load_fbab");
      check("load_fbab_c", 16'hfbab);
      idle();
      tick("hold_fbab");
      check("hold_fbab_c", 16'hfbab);

      // ------------------------------------------------------------ clears
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
      tick("clr_val");
      check("clr_val_c", 16'h7bab);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
      tick("clr_wat");
      check("clr_wat_c", 16'h3bab);

      // ------------------------------------------------------------ flush / sets
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      tick("flush");
      check("flush_c", 16'h0000);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
      tick("set_val");
      check("set_val_c", 16'h8000);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
      for (int i = 0; i < 40; i++) tick("set_wat_held");
      check("set_wat_held_c", 16'hc000);
      idle();
      tick("set_wat_stable");
      check("set_wat_stable_c", 16'hc000);

      // ------------------------------------------------------------ priority
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h3bab);
      tick("load_3bab");
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'hffff);
      tick("fls_over_en");
      check("fls_over_en_c", 16'h0000);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h3bab);
      tick("reload_3bab");
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0123);
      tick("en_over_set");
      check("en_over_set_c", 16'h0123);

      // ------------------------------------------------------------ conflicts
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'hc000);
      tick("load_c000");
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
      tick("val_conflict");
      check("val_conflict_c", 16'h4000);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      tick("flush2");
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
      tick("set_val2");
      check("set_val2_c", 16'h8000);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, '0);
      tick("wat_conflict");
      check("wat_conflict_c", 16'h8000);

      // ------------------------------------------------------------ random
      for (int i = 0; i < 400; i++) begin
         rnd_in = LW'($urandom);
         drive($urandom_range(0, 5) == 0,
               $urandom_range(0, 11) == 0,
               $urandom_range(0, 2) == 0,
               $urandom_range(0, 2) == 0,
               $urandom_range(0, 2) == 0,
               $urandom_range(0, 2) == 0,
               rnd_in);
         r = $urandom_range(0, 39);
         if (r == 0) async_reset_pulse("rand_async_reset");
         tick("rand_step");
      end

      idle();
      tick("final_hold");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/isq_lin.md
Name: isq_lin

Overview:
- One storage line (entry) of the issue queue.
- Holds one instruction payload plus two status bits: valid (val) and waiting (wat).
- Supports whole-line load, independent set/clear of each status bit, and flush.
- The issue-queue array instantiates one isq_lin per entry; its control logic drives the per-line strobes.

Parameters:
- INST_WIDTH, default 14: width of the instruction payload field.
- ISQ_LINE_WIDTH, default INST_WIDTH+2: total line width (payload + wat + val). Derived; must not be overridden independently.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  load enable; writes isq_lin_in into the line.
- clr_wat  input  1  clear waiting bit.
- set_wat  input  1  set waiting bit.
- clr_val  input  1  clear valid bit.
- set_val  input  1  set valid bit.
- fls  input  1  flush; zeroes the entire line.
- isq_lin_in  input  ISQ_LINE_WIDTH  line data to load.
- isq_lin_out  output  ISQ_LINE_WIDTH  current line contents, driven directly from the register.

Behaviour:
- Line layout, MSB first:
  - bit [ISQ_LINE_WIDTH-1] = val.
  - bit [ISQ_LINE_WIDTH-2] = wat.
  - bits [INST_WIDTH-1:0] = instruction payload.
- Storage: a single ISQ_LINE_WIDTH-bit register. isq_lin_out is that register, with no combinational path from the inputs.
- Reset: while rst_n=0, asynchronously force the register to all zeros, independent of clk. isq_lin_out=0 during reset and after its release until the next update.
- Update order at each rising clk edge when rst_n=1, highest priority first:
  1. fls=1: register <= 0. Overrides every other control that cycle.
  2. else en=1: register <= isq_lin_in, full width including val and wat. Set/clear strobes are ignored that cycle.
  3. else per-bit operations, each bit independent:
     - val: clr_val=1 -> 0; else set_val=1 -> 1; else hold.
     - wat: clr_wat=1 -> 0; else set_wat=1 -> 1; else hold.
     - Clear wins when set and clear of the same bit are both asserted.
     - Payload bits hold.
  4. No control asserted: register holds.
- Latency: every change is visible on isq_lin_out one clock after the controlling strobe is sampled. Strobes are level-sampled at each edge; a strobe held N cycles acts on N edges (idempotent for set/clr/fls).
- Reset mid-operation: reset overrides any in-progress strobe immediately. The line stays zero until a new en or set strobe.
- No X propagation: unknown-free reset state; all inputs are assumed driven.

Test Plan:
- Reset: rst_n pulsed low between edges with line preloaded to 0xffff -> isq_lin_out=0x0000 immediately, without waiting for a clk edge.
- Load: en=1, isq_lin_in=0xfbab for one cycle -> isq_lin_out=0xfbab after the edge; holds 0xfbab with en=0.
- Bit clears: from 0xfbab, clr_val one cycle -> 0x7bab; then clr_wat one cycle -> 0x3bab.
- Flush and sets: from 0x3bab, fls one cycle -> 0x0000; set_val one cycle -> 0x8000; set_wat held 40 cycles -> 0xc000, stable.
- Priority: with line at 0x3bab:
  - fls=1, en=1, isq_lin_in=0xffff, set_val=1 -> 0x0000.
  - en=1, isq_lin_in=0x0123, set_val=1 -> 0x0123.
- Set/clear conflict: from 0xc000, set_val=1 and clr_val=1 together -> 0x4000. From 0x8000, set_wat=1 and clr_wat=1 together -> 0x8000.
